// File: rtl/pipe_stage_buffer_pkg.sv
// Shared types and constants for the pipeline-stage buffer.
// Holds the buffer state encoding, which is also its occupancy count.
package pipe_buf_pkg;

    localparam int OCC_W = 2;

    // Replicated to CTRL_W wherever a NOP control word is needed.
    localparam bit CTRL_NOP = 1'b0;

    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/pipe_stage_buffer_if.sv
// One valid/ready beat channel (control + data payload) between pipeline stages.
// The master drives the beat; the slave answers with ready.
interface pipe_stage_buffer_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_buffer_entry.sv
// One payload slot (control + data) of the stage buffer.
// Clear has priority over load; ctrl and data clear independently.
module pipe_buf_entry
    import pipe_buf_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic              clear_ctrl,
    input  logic              clear_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    // NOTE: payload registers are reset because a NOP (zero ctrl) must show while empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl <= {CTRL_W{CTRL_NOP}};
        end else if (clear_ctrl) begin
            ctrl <= {CTRL_W{CTRL_NOP}};
        end else if (load) begin
            ctrl <= load_ctrl;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
        end else if (clear_data) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Pipeline-stage register with a two-entry skid store and flush-to-NOP.
// Define PIPE_STAGE_BUFFER_DATA_CLEAR_EN to zero data alongside ctrl on flush/drain.
module pipe_stage_buffer
    import pipe_buf_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush,
    pipe_stage_buffer_if.slave  up,
    pipe_stage_buffer_if.master dn,
    output logic [OCC_W-1:0]    occupancy
);

    buf_state_t state, next_state;

    logic              in_fire, out_fire;
    logic              main_load, main_from_skid, main_drain;
    logic              skid_load, skid_drain;
    logic              main_clear_ctrl, skid_clear_ctrl;
    logic              main_clear_data, skid_clear_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_next_ctrl;
    logic [DATA_W-1:0] main_data, skid_data, main_next_data;

    // Ready comes from the state register alone, so out_ready never reaches in_ready.
    assign up.ready  = (state != FULL);
    assign dn.valid  = (state != EMPTY);
    assign occupancy = state;
    assign in_fire   = up.valid & up.ready;
    assign out_fire  = dn.valid & dn.ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        next_state     = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_drain     = 1'b0;
        skid_load      = 1'b0;
        skid_drain     = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    next_state = ONE;
                    main_load  = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    next_state = FULL;
                    skid_load  = 1'b1;
                end else if (out_fire) begin
                    next_state = EMPTY;
                    main_drain = 1'b1;
                end
            end
            FULL: begin
                if (out_fire) begin
                    next_state     = ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_drain     = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
        // Flush wins; a beat leaving this cycle has already been handed downstream.
        if (flush) begin
            next_state     = EMPTY;
            main_load      = 1'b0;
            skid_load      = 1'b0;
        end
    end

    assign main_clear_ctrl = flush | main_drain;
    assign skid_clear_ctrl = flush | skid_drain;
`ifdef PIPE_STAGE_BUFFER_DATA_CLEAR_EN
    assign main_clear_data = main_clear_ctrl;
    assign skid_clear_data = skid_clear_ctrl;
`else
    assign main_clear_data = 1'b0;
    assign skid_clear_data = 1'b0;
`endif

    assign main_next_ctrl = main_from_skid ? skid_ctrl : up.ctrl;
    assign main_next_data = main_from_skid ? skid_data : up.data;

    pipe_buf_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (main_load),
        .clear_ctrl (main_clear_ctrl),
        .clear_data (main_clear_data),
        .load_ctrl  (main_next_ctrl),
        .load_data  (main_next_data),
        .ctrl       (main_ctrl),
        .data       (main_data)
    );

    pipe_buf_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (skid_load),
        .clear_ctrl (skid_clear_ctrl),
        .clear_data (skid_clear_data),
        .load_ctrl  (up.ctrl),
        .load_data  (up.data),
        .ctrl       (skid_ctrl),
        .data       (skid_data)
    );

    assign dn.ctrl = main_ctrl;
    assign dn.data = main_data;

endmodule

// File: doc/pipe_stage_buffer.md
# pipe_stage_buffer

Parametrised pipeline-stage register with valid/ready handshake, a two-entry skid store, and flush. It is the successor to the fixed-field stage buffers between decode, execute and memory stages. Backpressure is taken from the downstream stage without a combinational `out_ready`→`in_ready` path. Control fields are zeroed on flush, turning the stage into a NOP.

## Interface
- `DATA_W`, default 64: data payload width (operand values, constants, PC).
- `CTRL_W`, default 16: control payload width (alu op, reg dst, mem rd/wr, regwrite, opcode); all-zero encodes NOP.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `flush` in 1: synchronous; discard all held and incoming beats.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: buffer can accept; registered.
- `in_ctrl` in CTRL_W: upstream control.
- `in_data` in DATA_W: upstream data.
- `out_valid` out 1: downstream beat valid.
- `out_ready` in 1: downstream accepts.
- `out_ctrl` out CTRL_W: held control, zero when `out_valid`=0.
- `out_data` out DATA_W: held data.
- `occupancy` out 2: entries held, 0..2.

## Operation
- `in_fire` = `in_valid & in_ready`; `out_fire` = `out_valid & out_ready`.
- Storage: main entry (drives outputs) and skid entry.
- States and transitions:
  - EMPTY (0): `in_fire` → ONE, main ← in.
  - ONE (1):
    - `in_fire & out_fire` → ONE, main ← in.
    - `in_fire & !out_fire` → FULL, skid ← in.
    - `out_fire` only → EMPTY.
    - Otherwise hold.
  - FULL (2): `out_fire` → ONE, main ← skid; otherwise hold. `in_ready`=0 in FULL, so there is no input fire.
- Output and status encoding:
  - `in_ready` = (state != FULL), decoded from the state register only.
  - `out_valid` = (state != EMPTY).
  - `occupancy` = state encoding.
- Flush:
  - Priority over every transition. Next state is EMPTY and main/skid ctrl ← 0.
  - A beat offered on the flush cycle is dropped, even if `in_fire`.
  - A beat with `out_fire` on the flush cycle counts as delivered; downstream owns squashing it.
- Outputs when empty: `out_ctrl` = 0 whenever `out_valid`=0. `out_data` follows the Configuration section.
- Order: beats leave in acceptance order. There is no duplication or loss except on flush.

## Timing
- Reset (`reset_n` low, async): state EMPTY, `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_ctrl`=0, `out_data`=0, skid cleared. Inputs are ignored while reset is low.
- Reset deassertion takes effect at the first rising edge after `reset_n` goes high.
- Latency: beat accepted at edge N is on `out_*` after edge N (1 cycle), when the buffer was empty or drained that cycle.
- Throughput: 1 beat/cycle sustained with `out_ready`=1.
- Backpressure: `out_ready` low for one cycle while streaming fills the skid; `in_ready` drops after that edge. The recovery cycle drains the skid with no bubble.
- `out_ctrl`/`out_data` are stable while `out_valid & !out_ready`.
- Reset mid-operation: all held beats lost, outputs return to reset values immediately (asynchronously).
- Flush with `in_valid`=1 continuously: `out_valid`=0 for exactly one cycle after the flush edge. The next beat can be accepted on the cycle after flush.

## Configuration
- `PIPE_STAGE_BUFFER_DATA_CLEAR_EN`:
  - Defined: data payload is zeroed exactly like ctrl, on reset, on flush, and whenever an entry empties. `out_data`=0 whenever `out_valid`=0.
  - Undefined: data registers load only on accept and are cleared only by reset. Flush and drain leave stale data visible with `out_valid`=0, which saves enable/clear logic on wide DATA_W.

## Structure
- Package `pipe_buf_pkg`:
  - `buf_state_t` enum (EMPTY=2'd0, ONE=2'd1, FULL=2'd2).
  - `OCC_W`=2.
  - `CTRL_NOP` constant, all-zero.
- Sub-module `pipe_buf_entry`, instanced twice (main, skid): payload register with `load`, `clear_ctrl`, `clear_data` inputs and async active-low reset.
- Top holds the state register, fire/flush decode and the main-load mux (in vs skid).

## Test plan
- Reset then stream: `out_ready`=1, ctrl 0x0001..0x0004 on consecutive cycles → same values out one cycle later, back-to-back, `occupancy`=1.
- Backpressure: stream 0x0011, 0x0012, 0x0013 with `out_ready`=0 from cycle 2 → `occupancy`=2 and `in_ready`=0. Release → 0x0011, 0x0012, 0x0013 out in order, no loss.
- Flush when FULL with `in_valid`=1 (ctrl 0x00AA) → next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, `in_ready`=1, and 0x00AA never appears.
- Flush coincident with `out_fire` of 0x0021 → 0x0021 counted delivered once, buffer EMPTY.
- Async reset mid-stream (`reset_n` low between edges) → `out_valid`=0, `occupancy`=0 and `in_ready`=1 before the next edge.
- With and without `PIPE_STAGE_BUFFER_DATA_CLEAR_EN`: after draining data 0xDEAD → `out_data`=0 vs `out_data`=0xDEAD with `out_valid`=0.
